// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage data-memory access controller. It turns a load or
//               store from the EX/MEM register into a req/ack bus transaction
//               and stalls the pipeline until the access completes. It also
//               flags misaligned accesses and aborts bus cycles that time out.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] DataBus_B,
  output logic              mem_stall,
  output logic [DATA_W-1:0] ReadData,
  output logic              rd_valid,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  // The counter holds the number of BUSY cycles already spent without an ack.
  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;

  logic       w_access;
  logic       w_misalign;
  logic [7:0] w_cnt_next;

  assign w_access   = MemRd | MemWr;
  assign w_misalign = |ALUOut[1:0];
  assign w_cnt_next = r_cnt + 8'd1;

  // The stall is raised in the cycle the aligned access first appears, so the
  // EX/MEM register keeps presenting it. It is released in DONE so that the
  // pipeline advances past the finished access.
  assign mem_stall = ~reset &
                     (((r_state == ST_IDLE) & w_access & ~w_misalign) |
                      (r_state == ST_BUSY));

  // Access FSM. All bus signals and result outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      ReadData     <= '0;
      rd_valid     <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      rd_valid     <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_misalign) begin
              err_misalign <= 1'b1;
              ReadData     <= '0;
            end else begin
              // A simultaneous read and write is treated as a write.
              bus_req   <= 1'b1;
              bus_we    <= MemWr;
              bus_addr  <= {ALUOut[DATA_W-1:2], 2'b00};
              bus_wdata <= DataBus_B;
              r_cnt     <= 8'd0;
              r_state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // An ack in the final allowed cycle takes priority over the abort.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              ReadData <= bus_rdata;
              rd_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_cnt_next == c_timeout) begin
            bus_req     <= 1'b0;
            ReadData    <= '0;
            err_timeout <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        ST_DONE: begin
          // The inputs still show the completed access; never restart it.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Directed scenarios
//               followed by randomized loads/stores with random ack latency,
//               checked against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              reset;
  logic              MemRd;
  logic              MemWr;
  logic [DATA_W-1:0] ALUOut;
  logic [DATA_W-1:0] DataBus_B;
  logic              mem_stall;
  logic [DATA_W-1:0] ReadData;
  logic              rd_valid;
  logic              err_misalign;
  logic              err_timeout;
  logic              bus_req;
  logic              bus_we;
  logic [DATA_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  int          n_checks;
  int          n_errors;
  int          n_trans;      // bus transactions the model expects
  int          mon_trans;    // bus transactions observed on bus_req
  logic        prev_req;
  logic [31:0] m_rdata;      // model of the ReadData hold register

  mem_access_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRd       (MemRd),
    .MemWr       (MemWr),
    .ALUOut      (ALUOut),
    .DataBus_B   (DataBus_B),
    .mem_stall   (mem_stall),
    .ReadData    (ReadData),
    .rd_valid    (rd_valid),
    .err_misalign(err_misalign),
    .err_timeout (err_timeout),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count bus transactions as rising edges of bus_req.
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (bus_req && !prev_req) mon_trans = mon_trans + 1;
      prev_req = bus_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      MemRd   = 1'b0;
      MemWr   = 1'b0;
      bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("idle_stall", 32'(mem_stall), 32'd0);
      check_val("idle_req", 32'(bus_req), 32'd0);
      check_val("idle_rdv", 32'(rd_valid), 32'd0);
      next_cycle();
    end
    bus_ack = 1'b0;
  endtask

  // One access from the cycle it appears until the cycle after it completes.
  // ack_at: BUSY cycle number (1..) carrying the ack, 0 for never.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at,
                            input logic [31:0] rdata);
    logic timed_out;
    MemRd     = rd;
    MemWr     = wr;
    ALUOut    = addr;
    DataBus_B = wdata;
    bus_ack   = 1'b0;
    @(negedge clk);
    check_val("c0_req", 32'(bus_req), 32'd0);
    check_val("c0_rdv", 32'(rd_valid), 32'd0);
    if (addr[1:0] != 2'b00) begin
      check_val("mis_c0_stall", 32'(mem_stall), 32'd0);
      next_cycle();
      MemRd = 1'b0;
      MemWr = 1'b0;
      m_rdata = 32'd0;
      @(negedge clk);
      check_val("mis_pulse", 32'(err_misalign), 32'd1);
      check_val("mis_req", 32'(bus_req), 32'd0);
      check_val("mis_stall", 32'(mem_stall), 32'd0);
      check_val("mis_rdata", ReadData, m_rdata);
      next_cycle();
      return;
    end
    check_val("c0_stall", 32'(mem_stall), 32'd1);
    n_trans   = n_trans + 1;
    timed_out = 1'b0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      next_cycle();
      bus_ack   = (j == ack_at);
      bus_rdata = bus_ack ? rdata : $urandom;
      @(negedge clk);
      check_val("busy_req", 32'(bus_req), 32'd1);
      check_val("busy_we", 32'(bus_we), 32'(wr));
      check_val("busy_addr", bus_addr, {addr[31:2], 2'b00});
      check_val("busy_wdata", bus_wdata, wdata);
      check_val("busy_stall", 32'(mem_stall), 32'd1);
      if (j == ack_at) break;
      if (j == TIMEOUT) timed_out = 1'b1;
    end
    // DONE: inputs still hold the access; a stray ack must be ignored.
    next_cycle();
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    if (timed_out) m_rdata = 32'd0;
    else if (!wr) m_rdata = rdata;
    @(negedge clk);
    check_val("done_stall", 32'(mem_stall), 32'd0);
    check_val("done_req", 32'(bus_req), 32'd0);
    check_val("done_rdv", 32'(rd_valid), 32'(!timed_out && !wr));
    check_val("done_tmo", 32'(err_timeout), 32'(timed_out));
    check_val("done_rdata", ReadData, m_rdata);
    next_cycle();
    bus_ack = 1'b0;
    MemRd   = 1'b0;
    MemWr   = 1'b0;
  endtask

  initial begin
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    int          ack_at;
    int          sel;
    n_checks  = 0;
    n_errors  = 0;
    n_trans   = 0;
    mon_trans = 0;
    prev_req  = 1'b0;
    m_rdata   = 32'd0;
    reset     = 1'b1;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    ALUOut    = '0;
    DataBus_B = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;

    next_cycle();
    next_cycle();
    @(negedge clk);
    check_val("rst_req", 32'(bus_req), 32'd0);
    check_val("rst_stall", 32'(mem_stall), 32'd0);
    check_val("rst_rdata", ReadData, 32'd0);
    check_val("rst_flags", {29'd0, rd_valid, err_misalign, err_timeout}, 32'd0);
    check_val("rst_bus", bus_addr | bus_wdata | 32'(bus_we), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_cycles(2);

    // Directed scenarios.
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
    run_access(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 4, 32'h0);
    run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h0);
    run_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h0);
    run_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, TIMEOUT, 32'hA5A5_0F0F);
    run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2, 32'h1111_2222);
    run_access(1'b0, 1'b1, 32'h0000_0504, 32'h3333_4444, 1, 32'h0);
    run_access(1'b1, 1'b1, 32'h0000_0508, 32'h5555_6666, 2, 32'h7777_8888);

    // Reset asserted during BUSY cycle 2; a late ack must be ignored.
    MemRd  = 1'b1;
    MemWr  = 1'b0;
    ALUOut = 32'h0000_0300;
    @(negedge clk);
    check_val("rb_c0_stall", 32'(mem_stall), 32'd1);
    n_trans = n_trans + 1;
    next_cycle();
    @(negedge clk);
    check_val("rb_c1_req", 32'(bus_req), 32'd1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset     = 1'b0;
    MemRd     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    m_rdata   = 32'd0;
    @(negedge clk);
    check_val("rb_req", 32'(bus_req), 32'd0);
    check_val("rb_stall", 32'(mem_stall), 32'd0);
    check_val("rb_rdata", ReadData, m_rdata);
    check_val("rb_bus", bus_addr | 32'(bus_we), 32'd0);
    next_cycle();
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("rb_late_rdv", 32'(rd_valid), 32'd0);
    check_val("rb_late_req", 32'(bus_req), 32'd0);
    next_cycle();

    // Randomized accesses with random gaps and ack latency.
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 2));
      rd  = (sel != 1);
      wr  = (sel != 0);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       ack_at = 0;
        1:       ack_at = 1;
        2:       ack_at = TIMEOUT;
        default: ack_at = int'($urandom_range(1, TIMEOUT - 1));
      endcase
      run_access(rd, wr, addr, $urandom, ack_at, $urandom);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(1);
    check_val("bus_trans", 32'(mon_trans), 32'(n_trans));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
